// File: rtl/ram_dma_ctrl.sv
// rtl/ram_dma_ctrl.sv - FILL/COPY/SUM burst sequencer driving a single-port RAM.
// Optional FILL_INCR_EN: FILL writes pattern+i instead of a constant pattern.
module ram_dma_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              mem_ena,
  output logic              mem_wena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, FILL_W, COPY_RD, COPY_WR, SUM_RD, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] pat_q;

  logic [ADDR_W:0]   cnt_nxt;
  logic [ADDR_W-1:0] idx_nxt;
  logic              last;
  logic [DATA_W-1:0] fill_next;

  assign cnt_nxt = cnt + (ADDR_W + 1)'(1);
  assign idx_nxt = cnt_nxt[ADDR_W-1:0];
  assign last    = (cnt_nxt == len_q);

`ifdef FILL_INCR_EN
  assign fill_next = pat_q + DATA_W'(cnt_nxt);
`else
  assign fill_next = pat_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      cnt       <= '0;
      pat_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
      mem_ena   <= 1'b0;
      mem_wena  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            len_q <= len;
            pat_q <= pattern;
            cnt   <= '0;
            busy  <= 1'b1;
            if (op == 2'b10) result <= '0;
            if (len == '0 || op == 2'b11) begin
              state <= FIN;
              done  <= 1'b1;
              err   <= (op == 2'b11);
            end else begin
              // The first access is issued straight from the command inputs.
              mem_ena <= 1'b1;
              case (op)
                2'b00: begin
                  state     <= FILL_W;
                  mem_wena  <= 1'b1;
                  mem_addr  <= dst_addr;
                  mem_wdata <= pattern;
                end
                2'b01: begin
                  state    <= COPY_RD;
                  mem_addr <= src_addr;
                end
                default: begin
                  state    <= SUM_RD;
                  mem_addr <= src_addr;
                end
              endcase
            end
          end
        end
        FILL_W: begin
          if (last) begin
            state     <= FIN;
            done      <= 1'b1;
            mem_ena   <= 1'b0;
            mem_wena  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end else begin
            cnt       <= cnt_nxt;
            mem_addr  <= dst_q + idx_nxt;
            mem_wdata <= fill_next;
          end
        end
        COPY_RD: begin
          // mem_wdata doubles as the copy buffer for the following write.
          state     <= COPY_WR;
          mem_wena  <= 1'b1;
          mem_addr  <= dst_q + cnt[ADDR_W-1:0];
          mem_wdata <= mem_rdata;
        end
        COPY_WR: begin
          mem_wena  <= 1'b0;
          mem_wdata <= '0;
          if (last) begin
            state    <= FIN;
            done     <= 1'b1;
            mem_ena  <= 1'b0;
            mem_addr <= '0;
          end else begin
            state    <= COPY_RD;
            cnt      <= cnt_nxt;
            mem_addr <= src_q + idx_nxt;
          end
        end
        SUM_RD: begin
          result <= result + mem_rdata;
          if (last) begin
            state    <= FIN;
            done     <= 1'b1;
            mem_ena  <= 1'b0;
            mem_addr <= '0;
          end else begin
            cnt      <= cnt_nxt;
            mem_addr <= src_q + idx_nxt;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dma_ctrl.sv
// tb/tb_ram_dma_ctrl.sv - directed bench for ram_dma_ctrl with a per-cycle access model.
module tb_ram_dma_ctrl;

  logic        clk, rst_n, start;
  logic [1:0]  op;
  logic [4:0]  src_addr, dst_addr;
  logic [5:0]  len;
  logic [31:0] pattern;
  logic        busy, done, err;
  logic [31:0] result;
  logic        mem_ena, mem_wena;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  ram_dma_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .pattern(pattern),
    .busy(busy), .done(done), .err(err), .result(result),
    .mem_ena(mem_ena), .mem_wena(mem_wena), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bench-owned RAM with a backdoor port for preloading.
  logic [31:0] ram [32];
  logic        bd_we;
  logic [4:0]  bd_addr;
  logic [31:0] bd_data;
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_ena && mem_wena) ram[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = ram[mem_addr];

  typedef struct packed {
    logic        ena;
    logic        wena;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] exp_mem [32];
  logic [31:0] snap [32];
  logic [31:0] exp_result;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  // Expected cycle-by-cycle behaviour of one command, starting the cycle after acceptance.
  task automatic build(input logic [1:0] o, input logic [4:0] s, input logic [4:0] d,
                       input logic [5:0] n, input logic [31:0] p);
    exp_t        e;
    logic [31:0] v;
    if (o == 2'b10) exp_result = 32'd0;
    if (n != 0 && o != 2'b11) begin
      for (int i = 0; i < int'(n); i++) begin
        e = '0;
        e.ena  = 1'b1;
        e.busy = 1'b1;
        if (o == 2'b00) begin
          v = p;
`ifdef FILL_INCR_EN
          v = p + 32'(i);
`endif
          e.wena = 1'b1; e.addr = d + 5'(i); e.wdata = v;
          exp_mem[d + 5'(i)] = v;
          q.push_back(e);
        end else if (o == 2'b01) begin
          v = exp_mem[s + 5'(i)];
          e.addr = s + 5'(i);
          q.push_back(e);
          e.wena = 1'b1; e.addr = d + 5'(i); e.wdata = v;
          exp_mem[d + 5'(i)] = v;
          q.push_back(e);
        end else begin
          exp_result = exp_result + exp_mem[s + 5'(i)];
          e.addr = s + 5'(i);
          q.push_back(e);
        end
      end
    end
    e = '0;
    e.busy = 1'b1;
    e.done = 1'b1;
    e.err  = (o == 2'b11);
    q.push_back(e);
  endtask

  // One compare per cycle, #1 after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        chk("rst_outs", {busy, done, err, mem_ena, mem_wena, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_result", result, 32'd0);
      end else if (q.size() > 0) begin
        e = q.pop_front();
        chk("busy", {31'd0, busy}, {31'd0, e.busy});
        chk("done", {31'd0, done}, {31'd0, e.done});
        chk("err", {31'd0, err}, {31'd0, e.err});
        chk("mem_ena", {31'd0, mem_ena}, {31'd0, e.ena});
        chk("mem_wena", {31'd0, mem_wena}, {31'd0, e.wena});
        chk("mem_addr", {27'd0, mem_addr}, {27'd0, e.addr});
        if (e.wena || !e.ena) chk("mem_wdata", mem_wdata, e.wdata);
        if (e.done) chk("result", result, exp_result);
      end else begin
        chk("idle_ctl", {busy, done, err, mem_ena, mem_wena, mem_addr}, 32'd0);
        chk("idle_wdata", mem_wdata, 32'd0);
        chk("idle_result", result, exp_result);
      end
    end
  end

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    exp_mem[a] = d;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
  endtask

  task automatic run(input logic [1:0] o, input logic [4:0] s, input logic [4:0] d,
                     input logic [5:0] n, input logic [31:0] p, input int intrude,
                     output int lat);
    @(negedge clk);
    op = o; src_addr = s; dst_addr = d; len = n; pattern = p; start = 1'b1;
    build(o, s, d, n, p);
    @(posedge clk);
    #1;
    start = 1'b0;
    src_addr = ~s; dst_addr = ~d; len = 6'd1; pattern = ~p;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == intrude) begin
        @(negedge clk);
        start = 1'b1; op = 2'b00; dst_addr = 5'd20; len = 6'd4; pattern = 32'hDEADBEEF;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    if (done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL timeout: done not seen, got %0d cycles want <100", lat);
    end
    @(posedge clk);
    #1;
  endtask

  int          lat;
  logic [31:0] fv;

  initial begin
    rst_n = 1'b1; start = 1'b0; op = 2'b00; src_addr = '0; dst_addr = '0;
    len = '0; pattern = '0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    exp_result = 32'd0;
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'd0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(2'b00, 5'd0, 5'd0, 6'd32, 32'hA5A5A5A5, 0, lat);
    chk("fill32_lat", lat, 32'd33);
    for (int i = 0; i < 32; i++) begin
      fv = 32'hA5A5A5A5;
`ifdef FILL_INCR_EN
      fv = 32'hA5A5A5A5 + 32'(i);
`endif
      chk("fill32_word", ram[i], fv);
    end

    for (int i = 0; i < 4; i++) poke(5'(i), 32'(i + 1));
    run(2'b01, 5'd0, 5'd16, 6'd4, 32'h0, 0, lat);
    chk("copy_lat", lat, 32'd9);
    for (int i = 0; i < 4; i++) chk("copy_word", ram[16 + i], 32'(i + 1));

    poke(5'd30, 32'hFFFFFFFF); poke(5'd31, 32'd1); poke(5'd0, 32'd2); poke(5'd1, 32'd3);
    run(2'b10, 5'd30, 5'd0, 6'd4, 32'h0, 0, lat);
    chk("sum_lat", lat, 32'd5);
    chk("sum_wrap", result, 32'h00000005);

    run(2'b00, 5'd3, 5'd7, 6'd0, 32'h12345678, 0, lat);
    chk("len0_lat", lat, 32'd1);
    run(2'b11, 5'd3, 5'd7, 6'd5, 32'h12345678, 0, lat);
    chk("rsvd_lat", lat, 32'd1);

    poke(5'd8, 32'd10); poke(5'd9, 32'd20); poke(5'd10, 32'd30); poke(5'd11, 32'd40);
    run(2'b01, 5'd8, 5'd9, 6'd3, 32'h0, 0, lat);
    for (int i = 9; i < 12; i++) chk("overlap_word", ram[i], 32'd10);

    run(2'b00, 5'd0, 5'd4, 6'd8, 32'h11111111, 3, lat);
    chk("busy_start_lat", lat, 32'd9);

    // Reset during the third FILL cycle: only the first two writes land.
    @(negedge clk);
    op = 2'b00; dst_addr = 5'd24; len = 6'd8; pattern = 32'hC3C3C3C3; start = 1'b1;
    snap = exp_mem;
    build(2'b00, 5'd0, 5'd24, 6'd8, 32'hC3C3C3C3);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    exp_mem = snap;
    exp_mem[24] = 32'hC3C3C3C3;
`ifdef FILL_INCR_EN
    exp_mem[25] = 32'hC3C3C3C4;
`else
    exp_mem[25] = 32'hC3C3C3C3;
`endif
    exp_result = 32'd0;
    #1;
    chk("rst_mid_ena", {31'd0, mem_ena}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(2'b10, 5'd24, 5'd0, 6'd2, 32'h0, 0, lat);
    chk("post_rst_lat", lat, 32'd3);
`ifdef FILL_INCR_EN
    chk("post_rst_sum", result, 32'h87878787);
`else
    chk("post_rst_sum", result, 32'h87878786);
`endif

    for (int i = 0; i < 32; i++) chk("final_ram", ram[i], exp_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_dma_ctrl.md
# ram_dma_ctrl

Sequencer that acts as the initiator on the 32×32-bit single-port RAM port (ena/wena/addr/data_in/data_out, synchronous write, combinational read). It accepts one command at a time from the control side and executes it as a burst of RAM accesses:
- FILL: write a range.
- COPY: move a range.
- SUM: checksum a range.

It sits between the system control logic and the RAM, and is the only block driving the RAM port while busy.

## Interface
- ADDR_W, 5, RAM address width (depth 2^ADDR_W)
- DATA_W, 32, RAM word width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command strobe, sampled only in IDLE
- op  in  2  command: 00 FILL, 01 COPY, 10 SUM, 11 reserved
- src_addr  in  ADDR_W  source start address (COPY, SUM)
- dst_addr  in  ADDR_W  destination start address (FILL, COPY)
- len  in  ADDR_W+1  word count, 0..2^ADDR_W
- pattern  in  DATA_W  FILL data
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done for a reserved op
- result  out  DATA_W  SUM checksum, held until the next accepted SUM or reset
- mem_ena  out  1  to RAM ena
- mem_wena  out  1  to RAM wena
- mem_addr  out  ADDR_W  to RAM addr
- mem_wdata  out  DATA_W  to RAM data_in
- mem_rdata  in  DATA_W  from RAM data_out (valid in the same cycle as ena=1, wena=0)

## Operation
- States: IDLE, FILL_W, COPY_RD, COPY_WR, SUM_RD, FIN.
- IDLE:
  - start=1 latches op, src_addr, dst_addr, len and pattern into registers, and clears the word counter.
  - Next state by command:
    - len=0 → FIN.
    - op=11 → FIN with err.
    - Otherwise → the first state of the op.
  - Inputs are ignored while busy; start in a non-IDLE state is dropped.
- FILL_W: one write per cycle to dst+i, data = pattern. After the write with i=len−1 → FIN.
- COPY_RD: read at src+i; capture mem_rdata into the copy buffer → COPY_WR.
- COPY_WR: write the buffer to dst+i; i++ → COPY_RD, or → FIN after the last word.
- COPY runs in ascending order with no overlap correction. When dst is inside the source range above src, the propagated data is the defined result.
- SUM_RD: result accumulator += mem_rdata each cycle, at src+i. The accumulator is cleared when the SUM is accepted. After the last word → FIN.
- FIN: done=1 for one cycle (err=1 if the op was reserved), then → IDLE.
- Address arithmetic: modulo 2^ADDR_W, so ranges wrap from 31 to 0.
- Checksum: sum modulo 2^DATA_W; carries are discarded.
- mem_* outputs are decoded from registered state only:
  - mem_ena=1 only in FILL_W, COPY_RD, COPY_WR and SUM_RD.
  - mem_wena=1 only in FILL_W and COPY_WR.
  - mem_addr and mem_wdata are 0 whenever mem_ena=0.

## Timing
- Reset values: busy=0, done=0, err=0, result=0, mem_ena=0, mem_wena=0, mem_addr=0, mem_wdata=0; state=IDLE.
- Start accepted at edge T:
  - busy=1 from T+1.
  - The first RAM access is in cycle T+1.
- Latency from accepting edge T to the done pulse:
  - FILL, len N: done in cycle T+1+N.
  - SUM, len N: done in cycle T+1+N.
  - COPY, len N: done in cycle T+1+2N.
  - len=0 or reserved op: done in cycle T+1, with no RAM access.
- busy stays 1 through the FIN cycle and drops the cycle after.
- A start presented in the cycle after FIN (IDLE) is accepted: back-to-back commands have a 1-cycle gap.
- result updates on the final SUM read edge and is valid no later than the done cycle.
- Reset asserted mid-operation:
  - All outputs, including mem_ena, go to reset values immediately and asynchronously.
  - Words already written remain in the RAM; no done is issued.

## Configuration
- FILL_INCR_EN defined: FILL writes pattern+i (modulo 2^DATA_W) to word i, for address-tagged test images.
- FILL_INCR_EN undefined: every word of the range receives pattern unchanged.
- No other behaviour depends on the macro.

## Test plan
- Reset, then FILL dst=0 len=32 pattern=0xA5A5A5A5:
  - done exactly 33 cycles after start.
  - All 32 words read back 0xA5A5A5A5, or 0xA5A5A5A5+i with FILL_INCR_EN.
- COPY src=0 dst=16 len=4 with words 0..3 = 1,2,3,4 → words 16..19 = 1,2,3,4; done 9 cycles after start.
- SUM src=30 len=4 over words 30,31,0,1 = 0xFFFFFFFF,1,2,3:
  - Addresses wrap.
  - result=0x00000005 with the carry discarded.
- len=0 and op=11:
  - done in the next cycle with mem_ena never high.
  - err=1 only for op=11.
- start pulsed while busy during a FILL len=8 → ignored; exactly one done; RAM contains only the FILL.
- rst_n low during the 3rd cycle of FILL len=8:
  - mem_ena=0 and busy=0 immediately.
  - Only words dst..dst+1 are written.
  - A new command after reset works normally.
